// File: rtl/axi_lite_ctrl_slave.sv
// AXI4-Lite control-register responder: CTRL, IRQ_EN, STATUS, W1C IRQ_PEND and a GO strobe,
// with independently latched AW/W channels and a single-entry read path.
module axi_lite_ctrl_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     event_in,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_out,
   output logic                              go_pulse,
   output logic                              irq
);

   localparam int NB = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic                          r_run;
   logic                          r_aw_held;
   logic                          r_w_held;
   logic [2:0]                    r_aw_word;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
   logic [NB-1:0]                 r_wstrb;
   logic                          r_bvalid;
   logic [1:0]                    r_bresp;
   logic                          r_rvalid;
   logic [1:0]                    r_rresp;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_ctrl;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_en;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_status;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_pend;
   logic                          r_go;
   logic                          r_irq;

   logic                          w_commit;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_wmask;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_clr;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_rd_data;
   logic [1:0]                    w_rd_resp;
   logic                          w_unused;

   // r_run keeps every ready low while reset is held and for the edge that releases it
   assign S_AXI_AWREADY = r_run & ~r_aw_held & ~r_bvalid;
   assign S_AXI_WREADY  = r_run & ~r_w_held & ~r_bvalid;
   assign S_AXI_ARREADY = r_run & ~r_rvalid;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = r_rdata;
   assign ctrl_out      = r_ctrl;
   assign go_pulse      = r_go;
   assign irq           = r_irq;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

   for (genvar gi = 0; gi < NB; gi++) begin : g_mask
      assign w_wmask[gi*8 +: 8] = {8{r_wstrb[gi]}};
   end

   assign w_clr = (w_commit && r_aw_word == 3'd3) ? (r_wdata & w_wmask) : '0;

   always_comb begin
      w_rd_data = '0;
      w_rd_resp = RESP_OKAY;
      case (S_AXI_ARADDR[4:2])
         3'd0:    w_rd_data = r_ctrl;
         3'd1:    w_rd_data = r_en;
         3'd2:    w_rd_data = r_status;
         3'd3:    w_rd_data = r_pend;
         3'd4:    w_rd_data = '0;
         default: w_rd_resp = RESP_SLVERR;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_run     <= 1'b0;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_aw_word <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_ctrl    <= '0;
         r_en      <= '0;
         r_go      <= 1'b0;
      end else begin
         r_run <= 1'b1;
         r_go  <= 1'b0;
         if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            r_aw_held <= 1'b1;
            r_aw_word <= S_AXI_AWADDR[4:2];
         end
         if (S_AXI_WVALID && S_AXI_WREADY) begin
            r_w_held <= 1'b1;
            r_wdata  <= S_AXI_WDATA;
            r_wstrb  <= S_AXI_WSTRB;
         end
         if (w_commit) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= (r_aw_word >= 3'd5) ? RESP_SLVERR : RESP_OKAY;
            case (r_aw_word)
               3'd0:    r_ctrl <= (r_ctrl & ~w_wmask) | (r_wdata & w_wmask);
               3'd1:    r_en   <= (r_en & ~w_wmask) | (r_wdata & w_wmask);
               3'd4:    r_go   <= r_wstrb[0] & r_wdata[0];
               default: ;
            endcase
         end else if (r_bvalid && S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // A same-cycle event wins over a W1C clear on the same bit
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_status <= '0;
         r_pend   <= '0;
         r_irq    <= 1'b0;
      end else begin
         r_status <= status_in;
         r_pend   <= (r_pend & ~w_clr) | event_in;
         r_irq    <= |(r_pend & r_en);
      end
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
         r_rdata  <= '0;
      end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_rd_resp;
         r_rdata  <= w_rd_data;
      end else if (r_rvalid && S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

endmodule
